// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker
//   Filters the EQ/GT/LT flags of an 8-bit relational comparator through a persistence
//   window. A relation (EQUAL/ABOVE/BELOW) is committed only after PERSIST consecutive
//   identical legal samples. Commits that change the relation pulse change_pulse for one
//   cycle and bump a saturating counter. Non-one-hot flag samples set a sticky error bit.
//
//   Parameters
//     PERSIST      consecutive identical legal samples needed to commit (1..255)
//     CNT_W        width of change_cnt
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous, active-high reset
//     in_valid     sample qualifier for eq/gt/lt
//     eq, gt, lt   comparator flags
//     clr          (only with CMP_TRACK_CLR_EN) synchronous clear of change_cnt/err_flag
//     state_o      committed relation: 00 UNKNOWN, 01 EQUAL, 10 ABOVE, 11 BELOW
//     state_valid  high once any relation has been committed
//     change_pulse one-cycle pulse per committed change of state_o
//     change_cnt   saturating count of changes between two known relations
//     err_flag     sticky illegal-sample flag
//
//   Build option: define CMP_TRACK_CLR_EN to add the clr input.
//   All outputs are registered; no combinational input-to-output paths.

module cmp_result_tracker #(
  parameter int unsigned PERSIST = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             eq,
  input  logic             gt,
  input  logic             lt,
`ifdef CMP_TRACK_CLR_EN
  input  logic             clr,
`endif
  output logic [1:0]       state_o,
  output logic             state_valid,
  output logic             change_pulse,
  output logic [CNT_W-1:0] change_cnt,
  output logic             err_flag
);

  typedef enum logic [1:0] {
    RelUnknown = 2'b00,
    RelEqual   = 2'b01,
    RelAbove   = 2'b10,
    RelBelow   = 2'b11
  } rel_e;

  localparam logic [7:0]       PersistC = 8'(PERSIST);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  rel_e             state_q, state_d;
  rel_e             cand_q, cand_d;
  logic [7:0]       run_q, run_d;
  logic             valid_q, valid_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic one_hot;
  logic legal;
  logic illegal;
  logic commit;
  rel_e result;

  always_comb begin
    one_hot = (eq & ~gt & ~lt) | (~eq & gt & ~lt) | (~eq & ~gt & lt);
    legal   = in_valid & one_hot;
    illegal = in_valid & ~one_hot;
    if (eq) begin
      result = RelEqual;
    end else if (gt) begin
      result = RelAbove;
    end else begin
      result = RelBelow;
    end
  end

  // Run tracking: the candidate never holds RelUnknown after a legal sample, so the
  // first legal sample out of reset always starts a fresh run.
  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    if (legal) begin
      if (result == cand_q) begin
        run_d = (run_q >= PersistC) ? PersistC : run_q + 8'd1;
      end else begin
        cand_d = result;
        run_d  = 8'd1;
      end
    end
  end

  // Commit uses the post-update run length, so the PERSIST-th sample commits on its own edge.
  always_comb begin
    commit  = legal && (run_d == PersistC) && (cand_d != state_q);
    state_d = commit ? cand_d : state_q;
    valid_d = valid_q | commit;
    pulse_d = commit;
    cnt_d   = cnt_q;
    // Leaving UNKNOWN is not a change between two known relations.
    if (commit && (state_q != RelUnknown) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | illegal;
`ifdef CMP_TRACK_CLR_EN
    if (clr) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RelUnknown;
      cand_q  <= RelUnknown;
      run_q   <= 8'd0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state_o      = state_q;
  assign state_valid  = valid_q;
  assign change_pulse = pulse_q;
  assign change_cnt   = cnt_q;
  assign err_flag     = err_q;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Bench for cmp_result_tracker. Two instances share one stimulus stream:
//   instance a: PERSIST=4, CNT_W=8    instance b: PERSIST=1, CNT_W=2
// Expected outputs come from a history-window model: a relation commits when the last
// PERSIST legal results are all identical and differ from the committed relation.

module tb_cmp_result_tracker;

  localparam int unsigned PA = 4;
  localparam int unsigned CA = 8;
  localparam int unsigned PB = 1;
  localparam int unsigned CB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic eq = 1'b0;
  logic gt = 1'b0;
  logic lt = 1'b0;
`ifdef CMP_TRACK_CLR_EN
  logic clr = 1'b0;
`endif

  logic [1:0]    a_state, b_state;
  logic          a_valid, b_valid;
  logic          a_pulse, b_pulse;
  logic [CA-1:0] a_cnt;
  logic [CB-1:0] b_cnt;
  logic          a_err, b_err;

  always #5 clk = ~clk;

  cmp_result_tracker #(.PERSIST(PA), .CNT_W(CA)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .eq           (eq),
    .gt           (gt),
    .lt           (lt),
`ifdef CMP_TRACK_CLR_EN
    .clr          (clr),
`endif
    .state_o      (a_state),
    .state_valid  (a_valid),
    .change_pulse (a_pulse),
    .change_cnt   (a_cnt),
    .err_flag     (a_err)
  );

  cmp_result_tracker #(.PERSIST(PB), .CNT_W(CB)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .eq           (eq),
    .gt           (gt),
    .lt           (lt),
`ifdef CMP_TRACK_CLR_EN
    .clr          (clr),
`endif
    .state_o      (b_state),
    .state_valid  (b_valid),
    .change_pulse (b_pulse),
    .change_cnt   (b_cnt),
    .err_flag     (b_err)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model, index 0 = dut_a, 1 = dut_b.
  int m_persist [2] = '{PA, PB};
  int m_cmax    [2] = '{(1 << CA) - 1, (1 << CB) - 1};
  int m_hist    [2][256];
  int m_hlen    [2];
  int m_state   [2];
  int m_valid   [2];
  int m_pulse   [2];
  int m_cnt     [2];
  int m_err     [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hlen[i]  = 0;
      m_state[i] = 0;
      m_valid[i] = 0;
      m_pulse[i] = 0;
      m_cnt[i]   = 0;
      m_err[i]   = 0;
    end
  endtask

  task automatic model_edge(input bit v, input bit e, input bit g, input bit l, input bit c);
    int r;
    bit same;
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 0;
      if (v && (int'(e) + int'(g) + int'(l) == 1)) begin
        r = e ? 1 : (g ? 2 : 3);
        if (m_hlen[i] < m_persist[i]) begin
          m_hist[i][m_hlen[i]] = r;
          m_hlen[i]++;
        end else begin
          for (int k = 0; k < m_persist[i] - 1; k++) m_hist[i][k] = m_hist[i][k+1];
          m_hist[i][m_persist[i]-1] = r;
        end
        same = (m_hlen[i] == m_persist[i]);
        for (int k = 0; k < m_hlen[i]; k++) if (m_hist[i][k] != r) same = 0;
        if (same && r != m_state[i]) begin
          if (m_state[i] != 0 && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
          m_state[i] = r;
          m_valid[i] = 1;
          m_pulse[i] = 1;
        end
      end else if (v) begin
        m_err[i] = 1;
      end
      if (c) begin
        m_cnt[i] = 0;
        m_err[i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " a.state"}, 32'(a_state), 32'(m_state[0]));
    chk({tag, " a.valid"}, 32'(a_valid), 32'(m_valid[0]));
    chk({tag, " a.pulse"}, 32'(a_pulse), 32'(m_pulse[0]));
    chk({tag, " a.cnt"},   32'(a_cnt),   32'(m_cnt[0]));
    chk({tag, " a.err"},   32'(a_err),   32'(m_err[0]));
    chk({tag, " b.state"}, 32'(b_state), 32'(m_state[1]));
    chk({tag, " b.valid"}, 32'(b_valid), 32'(m_valid[1]));
    chk({tag, " b.pulse"}, 32'(b_pulse), 32'(m_pulse[1]));
    chk({tag, " b.cnt"},   32'(b_cnt),   32'(m_cnt[1]));
    chk({tag, " b.err"},   32'(b_err),   32'(m_err[1]));
  endtask

  // One clock: inputs applied away from the edge, outputs sampled 1 time unit after it.
  task automatic step(input string tag, input bit v, input bit e, input bit g, input bit l,
                      input bit c = 1'b0);
    bit cc;
    in_valid = v;
    eq = e;
    gt = g;
    lt = l;
`ifdef CMP_TRACK_CLR_EN
    clr = c;
    cc  = c;
`else
    cc  = 1'b0;
`endif
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(v, e, g, l, cc);
    #1;
`ifdef CMP_TRACK_CLR_EN
    clr = 1'b0;
`endif
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    check_all({tag, " async"});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all({tag, " released"});
  endtask

  // Legal sample, optionally preceded by an idle gap with random flags.
  task automatic legal_s(input string tag, input int r, input bit gap);
    if (gap) step({tag, " gap"}, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    step(tag, 1'b1, r == 1, r == 2, r == 3);
  endtask

  int exp_b_cnt [6] = '{0, 1, 2, 3, 3, 3};

  initial begin
    // 1: reset, then idle cycles with random flags
    do_reset("s1 reset");
    for (int i = 0; i < 3; i++)
      step("s1 idle", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    chk("s1 a.state zero", 32'(a_state), 32'd0);

    // 2: four gt commit ABOVE; fifth gt gives no pulse
    for (int i = 0; i < 4; i++) legal_s("s2 gt", 2, 1'b0);
    chk("s2 a.state above", 32'(a_state), 32'd2);
    chk("s2 a.pulse", 32'(a_pulse), 32'd1);
    chk("s2 a.cnt", 32'(a_cnt), 32'd0);
    legal_s("s2 gt5", 2, 1'b0);
    chk("s2 a.pulse gone", 32'(a_pulse), 32'd0);

    // 3: lt x3, gt, lt x4, done without and then with idle gaps
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        for (int i = 0; i < 4; i++) legal_s("s3 regt", 2, 1'b0);
      end
      for (int i = 0; i < 3; i++) legal_s("s3 lt", 3, pass == 1);
      legal_s("s3 gt", 2, pass == 1);
      for (int i = 0; i < 3; i++) legal_s("s3 lt", 3, pass == 1);
      chk("s3 a.state held", 32'(a_state), 32'd2);
      legal_s("s3 lt4", 3, pass == 1);
      chk("s3 a.state below", 32'(a_state), 32'd3);
      chk("s3 a.pulse", 32'(a_pulse), 32'd1);
    end
    chk("s3 a.cnt", 32'(a_cnt), 32'd3);

    // 4: illegal sample does not break the gt run
    legal_s("s4 gt", 2, 1'b0);
    legal_s("s4 gt", 2, 1'b0);
    step("s4 illegal", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("s4 a.err", 32'(a_err), 32'd1);
    legal_s("s4 gt", 2, 1'b0);
    chk("s4 a.state not yet", 32'(a_state), 32'd3);
    legal_s("s4 gt", 2, 1'b0);
    chk("s4 a.state above", 32'(a_state), 32'd2);
    chk("s4 a.err sticky", 32'(a_err), 32'd1);

    // 5: PERSIST=1, CNT_W=2 alternating eq/gt
    do_reset("s5 reset");
    for (int i = 0; i < 6; i++) begin
      legal_s("s5 alt", (i % 2 == 0) ? 1 : 2, 1'b0);
      chk("s5 b.pulse", 32'(b_pulse), 32'd1);
      chk("s5 b.cnt", 32'(b_cnt), 32'(exp_b_cnt[i]));
    end
`ifdef CMP_TRACK_CLR_EN
    step("s5 illegal", 1'b1, 1'b0, 1'b0, 1'b0);
    step("s5 clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s5 b.cnt clr", 32'(b_cnt), 32'd0);
    chk("s5 b.err clr", 32'(b_err), 32'd0);
    chk("s5 b.state held", 32'(b_state), 32'd2);
`endif

    // 6: async reset mid-cycle discards a partial run
    do_reset("s6 reset");
    for (int i = 0; i < 3; i++) legal_s("s6 lt", 3, 1'b0);
    #4;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("s6 mid-cycle rst");
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) legal_s("s6 lt after", 3, 1'b0);
    chk("s6 a.state no commit", 32'(a_state), 32'd0);
    legal_s("s6 lt4", 3, 1'b0);
    chk("s6 a.state below", 32'(a_state), 32'd3);

    // 7: random traffic
    for (int n = 0; n < 600; n++) begin
      bit v, e, g, l, c;
      int r;
      if ($urandom_range(99) < 3) begin
        do_reset("rnd reset");
      end else begin
        v = ($urandom_range(99) < 75);
        if ($urandom_range(99) < 85) begin
          r = ($urandom_range(99) < 60) ? 2 + int'($urandom_range(1)) : 1 + int'($urandom_range(2));
          e = (r == 1);
          g = (r == 2);
          l = (r == 3);
        end else begin
          e = 1'($urandom);
          g = 1'($urandom);
          l = 1'($urandom);
        end
        c = ($urandom_range(99) < 4);
        step("rnd", v, e, g, l, c);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
